// File: rtl/code25_pkg.sv
// -----------------------------------------------------------------------------
// code25_pkg
// Shared definitions for the 2-of-5 code front end and checker stage.
//   CODE_W / SEL_W : widths of the code field (EN1..EN5) and selector (N0..N2)
//   IN_W           : width of the combined {sel, code} vector
//   state_t        : sampler FSM states
//   is_two_of_five : true when exactly two code bits are set
// -----------------------------------------------------------------------------
package code25_pkg;

  localparam int CODE_W = 5;
  localparam int SEL_W  = 3;
  localparam int IN_W   = CODE_W + SEL_W;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    COMMIT  = 2'd1,
    VALID   = 2'd2,
    INVALID = 2'd3
  } state_t;

  function automatic logic is_two_of_five(input logic [CODE_W-1:0] code);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < CODE_W; i++) begin
      ones = ones + 32'(code[i]);
    end
    return (ones == 32'd2);
  endfunction

endpackage

// File: rtl/code25_debouncer.sv
// -----------------------------------------------------------------------------
// code25_debouncer
// Two-flop synchroniser followed by a candidate/counter debouncer on a
// DATA_W-bit vector. A change of the synchronised value restarts the count;
// identical samples advance it until it saturates at DEBOUNCE_CYCLES-1.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   raw_i       in   DATA_W  asynchronous raw inputs
//   stable_o    out  1       counter saturated and synchronised value == candidate
//   candidate_o out  DATA_W  value currently being debounced
// -----------------------------------------------------------------------------
module code25_debouncer #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] raw_i,
  output logic              stable_o,
  output logic [DATA_W-1:0] candidate_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;
  logic [DATA_W-1:0] candidate;
  logic [CNT_W-1:0]  count;

  // Stage p0/p1: metastability chain, all bits sampled together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_i;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: any difference wins over saturation, so a change landing
  // on the saturating cycle restarts the count rather than committing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate <= '0;
      count     <= '0;
    end else if (sync_p1 != candidate) begin
      candidate <= sync_p1;
      count     <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + 1'b1;
    end
  end

  assign stable_o    = (count == CNT_MAX) && (sync_p1 == candidate);
  assign candidate_o = candidate;

endmodule

// File: rtl/code25_input_sampler.sv
// -----------------------------------------------------------------------------
// code25_input_sampler
// Front end for the 2-of-5 code checker: synchronises and debounces the code
// and selector switches as one vector, commits stable changes to registered
// outputs and qualifies the committed code as two-hot.
//
// Optional build macro: CODE25_ERR_COUNT_EN adds err_cnt_o, a saturating
// count of committed codes that were not two-hot.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   sw_code_i    in   5  raw code switches (bit0 = EN1 .. bit4 = EN5)
//   sw_sel_i     in   3  raw selector switches (bit0 = N0 .. bit2 = N2)
//   code_o       out  5  committed code
//   sel_o        out  3  committed selector
//   code_valid_o out  1  committed code is two-hot
//   code_err_o   out  1  committed code is not two-hot
//   update_o     out  1  one-cycle pulse per commit
//   err_cnt_o    out  8  invalid-commit count (CODE25_ERR_COUNT_EN only)
// -----------------------------------------------------------------------------
module code25_input_sampler
  import code25_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] sw_code_i,
  input  logic [SEL_W-1:0]  sw_sel_i,
  output logic [CODE_W-1:0] code_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              code_valid_o,
  output logic              code_err_o,
  output logic              update_o
`ifdef CODE25_ERR_COUNT_EN
  ,
  output logic [7:0]        err_cnt_o
`endif
);

  logic            stable;
  logic [IN_W-1:0] candidate;
  logic            cand_new;
  logic            cand_two_hot;
  logic            out_two_hot;
  logic            commit_en;
  state_t          state;
  state_t          next_state;

  code25_debouncer #(
    .DATA_W          (IN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_i       ({sw_sel_i, sw_code_i}),
    .stable_o    (stable),
    .candidate_o (candidate)
  );

  assign cand_new     = (candidate != {sel_o, code_o});
  assign cand_two_hot = is_two_of_five(candidate[CODE_W-1:0]);
  assign out_two_hot  = is_two_of_five(code_o);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. VALID/INVALID fall back to SETTLE on loss of stability
  // rather than on s != candidate alone: a change arriving during COMMIT has
  // already been absorbed into the candidate by the time the FSM leaves COMMIT,
  // and only the restarted counter still reveals it.
  always_comb begin
    next_state = state;
    case (state)
      SETTLE: begin
        if (stable) begin
          if (cand_new) begin
            next_state = COMMIT;
          end else if (out_two_hot) begin
            next_state = VALID;
          end else begin
            next_state = INVALID;
          end
        end
      end
      COMMIT: begin
        next_state = out_two_hot ? VALID : INVALID;
      end
      VALID, INVALID: begin
        if (!stable) begin
          next_state = SETTLE;
        end
      end
      default: next_state = SETTLE;
    endcase
  end

  // Output decode: the commit is taken on the edge entering COMMIT, so the
  // registered outputs and update_o are visible for the whole COMMIT cycle.
  always_comb begin
    commit_en = (state == SETTLE) && (next_state == COMMIT);
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_o       <= '0;
      sel_o        <= '0;
      code_valid_o <= 1'b0;
      code_err_o   <= 1'b0;
      update_o     <= 1'b0;
    end else begin
      update_o <= commit_en;
      if (commit_en) begin
        code_o       <= candidate[CODE_W-1:0];
        sel_o        <= candidate[IN_W-1:CODE_W];
        code_valid_o <= cand_two_hot;
        code_err_o   <= !cand_two_hot;
      end
    end
  end

`ifdef CODE25_ERR_COUNT_EN
  // Invalid-commit counter, saturating at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_o <= '0;
    end else if (commit_en && !cand_two_hot && (err_cnt_o != 8'hFF)) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_code25_input_sampler.sv
module tb_code25_input_sampler;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sw_code = 5'b0;
  logic [2:0] sw_sel = 3'b0;
  logic [4:0] code;
  logic [2:0] sel;
  logic       code_valid;
  logic       code_err;
  logic       update;
`ifdef CODE25_ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int upd_seen = 0;

  always #5 clk = ~clk;

  code25_input_sampler #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_code_i    (sw_code),
    .sw_sel_i     (sw_sel),
    .code_o       (code),
    .sel_o        (sel),
    .code_valid_o (code_valid),
    .code_err_o   (code_err),
    .update_o     (update)
`ifdef CODE25_ERR_COUNT_EN
    ,
    .err_cnt_o    (err_cnt)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pin samples per clock edge. hist[0] is the newest pin
  // sample; the synchronised value lags it by two edges (hist[2]). A commit
  // happens when D+1 consecutive synchronised samples agree and differ from
  // what is committed. After reset the synchroniser and candidate read as
  // zero, and older history is a sentinel that matches nothing.
  logic [8:0] hist [0:D+2];
  logic [4:0] m_code;
  logic [2:0] m_sel;
  logic       m_valid, m_err, m_upd;
  int         m_errcnt;

  task automatic model_reset();
    for (int i = 0; i <= D + 2; i++) hist[i] = 9'h100;
    hist[0] = 9'h000;
    hist[1] = 9'h000;
    hist[2] = 9'h000;
    m_code = '0; m_sel = '0; m_valid = 0; m_err = 0; m_upd = 0; m_errcnt = 0;
  endtask

  task automatic model_step();
    logic st;
    logic two;
    for (int i = D + 2; i >= 1; i--) hist[i] = hist[i-1];
    hist[0] = {1'b0, sw_sel, sw_code};
    st = 1'b1;
    for (int i = 3; i <= D + 2; i++) if (hist[i] != hist[2]) st = 1'b0;
    m_upd = 1'b0;
    if (st && (hist[2][7:0] != {m_sel, m_code})) begin
      m_code = hist[2][4:0];
      m_sel  = hist[2][7:5];
      two    = ($countones(hist[2][4:0]) == 2);
      m_valid = two;
      m_err   = !two;
      m_upd   = 1'b1;
      if (!two && m_errcnt < 255) m_errcnt++;
    end
  endtask

  // Per-cycle compare against the model
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("cyc_code", int'(code), int'(m_code));
    check("cyc_sel", int'(sel), int'(m_sel));
    check("cyc_valid", int'(code_valid), int'(m_valid));
    check("cyc_err", int'(code_err), int'(m_err));
    check("cyc_update", int'(update), int'(m_upd));
`ifdef CODE25_ERR_COUNT_EN
    check("cyc_err_cnt", int'(err_cnt), m_errcnt);
`endif
    if (update) upd_seen++;
  end

  task automatic drive(input logic [4:0] c, input logic [2:0] s);
    @(negedge clk);
    sw_code = c;
    sw_sel  = s;
  endtask

  // Edges after the drive until update is seen; 0 when the bound expires
  task automatic wait_update(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #2;
      if (update) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int u0;
    int bad;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_code", int'(code), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_valid", int'(code_valid), 0);
    check("rst_err", int'(code_err), 0);
    check("rst_update", int'(update), 0);
`ifdef CODE25_ERR_COUNT_EN
    check("rst_err_cnt", int'(err_cnt), 0);
`endif
    rst_n = 1'b1;

    // 1: first commit, latency 7
    drive(5'b00011, 3'b101);
    wait_update(20, n);
    check("t1_latency", n, 7);
    check("t1_code", int'(code), 5'b00011);
    check("t1_sel", int'(sel), 3'b101);
    check("t1_valid", int'(code_valid), 1);
    check("t1_err", int'(code_err), 0);
    repeat (4) @(negedge clk);

    // 2: three-hot code is an error
    drive(5'b00111, 3'b101);
    wait_update(20, n);
    check("t2_latency", n, 7);
    check("t2_err", int'(code_err), 1);
    check("t2_valid", int'(code_valid), 0);
`ifdef CODE25_ERR_COUNT_EN
    check("t2_err_cnt", int'(err_cnt), 1);
`endif
    drive(5'b00011, 3'b101);
    wait_update(20, n);
    check("t2_restore", n, 7);
    repeat (4) @(negedge clk);

    // 3: bit2 toggling every 2 cycles never commits
    u0 = upd_seen;
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 5'b00111 : 5'b00011, 3'b101);
      @(negedge clk);
    end
    drive(5'b00011, 3'b101);
    repeat (15) @(negedge clk);
    check("t3_no_update", upd_seen, u0);
    check("t3_code", int'(code), 5'b00011);
    check("t3_valid", int'(code_valid), 1);

    // 4: reset two cycles before the commit
    drive(5'b10001, 3'b101);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_code_async", int'(code), 0);
    check("t4_sel_async", int'(sel), 0);
    check("t4_valid_async", int'(code_valid), 0);
    check("t4_update_async", int'(update), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_update(20, n);
    check("t4_recommit_latency", n, 7);
    check("t4_code", int'(code), 5'b10001);
    check("t4_valid", int'(code_valid), 1);
`ifdef CODE25_ERR_COUNT_EN
    check("t4_err_cnt", int'(err_cnt), 0);
`endif
    repeat (4) @(negedge clk);

    // 5: selector-only change
    drive(5'b01010, 3'b101);
    wait_update(20, n);
    check("t5_setup", n, 7);
    repeat (3) @(negedge clk);
    drive(5'b01010, 3'b010);
    u0 = upd_seen;
    wait_update(20, n);
    check("t5_latency", n, 7);
    check("t5_sel", int'(sel), 3'b010);
    check("t5_code", int'(code), 5'b01010);
    check("t5_valid", int'(code_valid), 1);
    repeat (10) @(negedge clk);
    check("t5_single_update", upd_seen, u0 + 1);

    // 6: 300 invalid commits alternating with a valid one
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      drive(5'b11111, 3'b101);
      wait_update(20, n);
      if (n != 7) bad++;
      drive(5'b00011, 3'b101);
      wait_update(20, n);
      if (n != 7) bad++;
    end
    check("t6_latency_all", bad, 0);
    check("t6_valid", int'(code_valid), 1);
`ifdef CODE25_ERR_COUNT_EN
    check("t6_err_cnt_sat", int'(err_cnt), 255);
`endif
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
